// File: rtl/sr_grant_arbiter_pkg.sv
// ============================================================================
// sr_arb_pkg : shared types, default parameters and width helper for the
//              set/reset-flag round-robin grant arbiter.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package sr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      REL  = 2'd2
   } state_e;

   localparam int unsigned N_REQ_DEF    = 4;
   localparam int unsigned HOLD_MAX_DEF = 15;

   // Width of an index/counter able to hold 0..n-1, never narrower than 1 bit.
   function automatic int unsigned width_of(input int unsigned n);
      int unsigned w;
      w = 1;
      if (n > 2) w = $clog2(n);
      return w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sr_grant_arbiter_if.sv
// ============================================================================
// sr_grant_arbiter_if : request/grant bundle between requesters and arbiter.
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface sr_grant_arbiter_if
   import sr_arb_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF
);
   localparam int unsigned ID_W = width_of(N_REQ);

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] done;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0]  grant_id;
   logic             busy;
   logic             timeout;

   modport master (
      output req, done,
      input  grant, grant_id, busy, timeout
   );

   modport slave (
      input  req, done,
      output grant, grant_id, busy, timeout
   );

endinterface

`default_nettype wire

// File: rtl/sr_grant_arbiter_flag.sv
// ============================================================================
// sr_flag  : synchronous set/reset ownership cell, reset input dominates set.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sr_flag (
   input  logic clk,
   input  logic reset,
   input  logic s,
   input  logic r,
   output logic q,
   output logic qbar
);

   logic flag_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         flag_q <= 1'b0;
      end else if (r) begin
         flag_q <= 1'b0;
      end else if (s) begin
         flag_q <= 1'b1;
      end
   end

   assign q    = flag_q;
   assign qbar = ~flag_q;

endmodule

`default_nettype wire

// File: rtl/sr_grant_arbiter.sv
// ============================================================================
// sr_grant_arbiter : round-robin arbiter with per-requester set/reset flags,
//                    mandatory release dead cycle and bounded hold time.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module sr_grant_arbiter
   import sr_arb_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEF,
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   sr_grant_arbiter_if.slave bus
);

   localparam int unsigned ID_W  = width_of(N_REQ);
   localparam int unsigned CNT_W = width_of(HOLD_MAX + 1);

   state_e           state_q, state_d;
   logic [ID_W-1:0]  owner_q, owner_d;
   logic [ID_W-1:0]  ptr_q,   ptr_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             timeout_q, timeout_d;

   logic [ID_W-1:0]  winner;
   logic             found;
   logic [N_REQ-1:0] set_p, rst_p;
   logic [N_REQ-1:0] flag_q, flag_qbar;
   logic             own_done, own_req, hold_hit;

   assign own_done = bus.done[owner_q];
   assign own_req  = bus.req[owner_q];
   assign hold_hit = (cnt_q == CNT_W'(HOLD_MAX));

   // First requester at or after ptr, wrapping; works for non-power-of-two N_REQ.
   always_comb begin : rr_search
      int              idx;
      logic [ID_W-1:0] cand;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      cand   = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
         cand = ID_W'(idx);
         if (!found && bus.req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   // The reset pulse is issued on the last OWN cycle so the flag is already
   // clear throughout REL; set and reset therefore live in disjoint states.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      set_p     = '0;
      rst_p     = '0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (found) begin
               set_p[winner] = 1'b1;
               owner_d       = winner;
               cnt_d         = CNT_W'(1);
               state_d       = OWN;
            end
         end
         OWN: begin
            if (!hold_hit) cnt_d = cnt_q + CNT_W'(1);
            if (own_done || !own_req || hold_hit) begin
               rst_p[owner_q] = 1'b1;
               timeout_d      = hold_hit && !own_done;
               state_d        = REL;
            end
         end
         REL: begin
            ptr_d   = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
            owner_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   for (genvar g = 0; g < int'(N_REQ); g++) begin : g_flag
      sr_flag u_flag (
         .clk   (clk),
         .reset (reset),
         .s     (set_p[g]),
         .r     (rst_p[g]),
         .q     (flag_q[g]),
         .qbar  (flag_qbar[g])
      );
   end

   assign bus.grant    = flag_q;
   assign bus.busy     = ~&flag_qbar;
   assign bus.grant_id = owner_q;
   assign bus.timeout  = timeout_q;

endmodule

`default_nettype wire
